// File: rtl/kplic_core_if.sv
// Register bus between the interrupt handler side (master) and kplic_core (slave).
// One-cycle read/write strobes; read data is valid the cycle after reg_rd.
interface kplic_core_if;
    logic [7:0]  reg_addr;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    modport master (output reg_addr, output reg_wr, output reg_rd, output reg_wdata, input reg_rdata);
    modport slave  (input reg_addr, input reg_wr, input reg_rd, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/kplic_core.sv
// kplic_core: platform interrupt controller with per-source gateways, priority arbitration, claim/complete.
// Define KPLIC_EDGE_TRIG_EN to implement EDGECFG (per-source edge-triggered gateways).
module kplic_core #(
    parameter int unsigned N_SRC  = 8,
    parameter int unsigned PRIO_W = 3
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    input  logic [N_SRC-1:0] src_irq,
    kplic_core_if.slave      bus,
    output logic             kplic_int
);
    localparam logic [7:0] A_PEND  = 8'h00;
    localparam logic [7:0] A_EN    = 8'h04;
    localparam logic [7:0] A_THR   = 8'h08;
    localparam logic [7:0] A_CLAIM = 8'h0C;
    localparam logic [7:0] A_EDGE  = 8'h10;

    logic [N_SRC-1:0]  sync1, sync2;
    logic [N_SRC:1]    pending, pending_n, in_service, in_service_n, enable;
    logic [PRIO_W-1:0] threshold;
    logic [PRIO_W-1:0] prio [N_SRC:1];
    logic [4:0]        best_id;
    logic [PRIO_W-1:0] best_prio;
    logic              claim, complete, gw_set;
    logic [31:0]       rd_val;
`ifdef KPLIC_EDGE_TRIG_EN
    logic [N_SRC-1:0]  sync3;
    logic [N_SRC:1]    edge_cfg;
`endif

    // Ascending scan with strict '>' gives the lowest ID on priority ties; priority 0 never wins.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            if (pending[i] && enable[i] && prio[i] > best_prio) begin
                best_id   = 5'(i);
                best_prio = prio[i];
            end
        end
    end

    always_comb begin
        claim        = bus.reg_rd && (bus.reg_addr == A_CLAIM);
        complete     = bus.reg_wr && (bus.reg_addr == A_CLAIM);
        pending_n    = pending;
        in_service_n = in_service;
        gw_set       = 1'b0;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            gw_set = sync2[i-1] && !pending[i] && !in_service[i];
`ifdef KPLIC_EDGE_TRIG_EN
            if (edge_cfg[i])
                gw_set = sync2[i-1] && !sync3[i-1];
`endif
            if (gw_set)
                pending_n[i] = 1'b1;
            if (complete && bus.reg_wdata == 32'(i))
                in_service_n[i] = 1'b0;
            // Claim wins over a same-edge gateway set of the same ID.
            if (claim && best_id == 5'(i)) begin
                pending_n[i]    = 1'b0;
                in_service_n[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.reg_addr)
            A_PEND:  rd_val[N_SRC:1]    = pending;
            A_EN:    rd_val[N_SRC:1]    = enable;
            A_THR:   rd_val[PRIO_W-1:0] = threshold;
            A_CLAIM: rd_val[4:0]        = best_id;
`ifdef KPLIC_EDGE_TRIG_EN
            A_EDGE:  rd_val[N_SRC:1]    = edge_cfg;
`endif
            default: begin
                for (int unsigned i = 1; i <= N_SRC; i++)
                    if (bus.reg_addr == 8'(64 + 4 * i))
                        rd_val[PRIO_W-1:0] = prio[i];
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            sync1         <= '0;
            sync2         <= '0;
            pending       <= '0;
            in_service    <= '0;
            enable        <= '0;
            threshold     <= '0;
            kplic_int     <= 1'b0;
            bus.reg_rdata <= '0;
            for (int unsigned i = 1; i <= N_SRC; i++)
                prio[i] <= '0;
`ifdef KPLIC_EDGE_TRIG_EN
            sync3    <= '0;
            edge_cfg <= '0;
`endif
        end else begin
            sync1      <= src_irq;
            sync2      <= sync1;
            pending    <= pending_n;
            in_service <= in_service_n;
            kplic_int  <= (best_id != '0) && (best_prio > threshold);
`ifdef KPLIC_EDGE_TRIG_EN
            sync3 <= sync2;
`endif
            if (bus.reg_rd)
                bus.reg_rdata <= rd_val;
            if (bus.reg_wr) begin
                case (bus.reg_addr)
                    A_EN:  enable    <= bus.reg_wdata[N_SRC:1];
                    A_THR: threshold <= bus.reg_wdata[PRIO_W-1:0];
`ifdef KPLIC_EDGE_TRIG_EN
                    A_EDGE: edge_cfg <= bus.reg_wdata[N_SRC:1];
`endif
                    default: begin
                        for (int unsigned i = 1; i <= N_SRC; i++)
                            if (bus.reg_addr == 8'(64 + 4 * i))
                                prio[i] <= bus.reg_wdata[PRIO_W-1:0];
                    end
                endcase
            end
        end
    end
endmodule
